blob_frame_streamer: RTL and testbench

- Transmit side of the blob-counter bit-stream interface.
- Thresholds the camera grayscale pixel stream into a 1-bit mask and stores one full frame in on-chip RAM.
- Replays the frame to the blob counter as one start pulse followed by IMG_COL*IMG_ROW contiguous mask bits, one per clock.
- Holds off the next frame until the counter returns its result pulse.

---
 rtl/blob_frame_streamer.sv | 173 +++++++++++++++++
 tb/tb_blob_frame_streamer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_frame_streamer.sv
// blob_frame_streamer: thresholds a raster grayscale stream into a 1-bit
// mask, buffers one full frame in on-chip RAM, then replays it to the blob
// counter as a start pulse followed by IMG_COL*IMG_ROW contiguous mask bits.
// The next frame is held off until the counter returns i_blob_done.
// Optional feature: define BLOB_BORDER_CLEAR_EN to force the outermost
// rows/columns of the mask to 0.
//
// Handshake: there is no backpressure. o_valid is a one-cycle frame-start
// pulse; o_seq then carries one mask bit on each of the next
// IMG_COL*IMG_ROW cycles without gaps. i_blob_done is a one-cycle pulse that
// is honoured only while waiting for the result; i_sof is a one-cycle strobe.
// o_state exposes the FSM state for debug and checker binding.
module blob_frame_streamer #(
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter int ADDR_W  = 19
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sof,
  input  logic       i_pix_valid,
  input  logic [7:0] i_gray,
  input  logic [7:0] i_threshold,
  input  logic       i_blob_done,
  output logic       o_valid,
  output logic       o_seq,
  output logic       o_busy,
  output logic [7:0] o_drop_cnt,
  output logic [2:0] o_state
);

  localparam int NPIX = IMG_COL * IMG_ROW;
  localparam logic [ADDR_W-1:0] LAST_W   = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_R   = (ADDR_W + 1)'(NPIX);
  localparam logic [ADDR_W:0]   LAST_R   = (ADDR_W + 1)'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_START   = 3'd2,
    S_STREAM  = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   rd_idx;     // index of the bit currently on o_seq
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              wr_en;
  logic              wr_bit;
  logic              rdata;
  logic [7:0]        drop;
  logic              mem [NPIX];

`ifdef BLOB_BORDER_CLEAR_EN
  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             border;

  assign border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign wr_bit = (i_gray >= i_threshold) && !border;

  // Raster position of the next accepted pixel; restarts with every frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_sof && (state == S_IDLE || state == S_CAPTURE)) begin
      col <= '0;
      row <= '0;
    end else if (wr_en) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row != ROW_LAST) row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end
`else
  assign wr_bit = (i_gray >= i_threshold);
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, RAM strobes and stream outputs.
  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    o_seq     = 1'b0;
    o_busy    = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_sof) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A new start-of-frame aborts the capture and discards this pixel.
        if (!i_sof && i_pix_valid) begin
          wr_en = 1'b1;
          if (waddr == LAST_W) state_nxt = S_START;
        end
      end
      S_START: begin
        o_valid   = 1'b1;
        rd_en     = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (rd_idx == NPIX_R) begin
          // Trailing cycle after the last bit; o_seq stays low.
          state_nxt = S_WAIT;
        end else begin
          o_seq = rdata;
          // Read one ahead so the next bit is ready without a gap.
          if (rd_idx < LAST_R) begin
            rd_en   = 1'b1;
            rd_addr = rd_idx[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (i_blob_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write address, stream index and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      waddr  <= '0;
      rd_idx <= '0;
      drop   <= '0;
    end else begin
      case (state)
        S_IDLE:    if (i_sof) waddr <= '0;
        S_CAPTURE: begin
          if (i_sof) waddr <= '0;
          else if (i_pix_valid && waddr != LAST_W) waddr <= waddr + ADDR_W'(1);
        end
        S_START:   rd_idx <= '0;
        S_STREAM:  if (rd_idx != NPIX_R) rd_idx <= rd_idx + (ADDR_W + 1)'(1);
        default:   ;
      endcase
      if (i_sof && (state == S_START || state == S_STREAM || state == S_WAIT) &&
          drop != 8'hFF)
        drop <= drop + 8'd1;
    end
  end

  // Frame RAM: one write port, synchronous read port.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[waddr] <= wr_bit;
    if (rd_en) rdata <= mem[rd_addr];
  end

  assign o_drop_cnt = drop;
  assign o_state    = state;

endmodule

// File: tb/tb_blob_frame_streamer.sv
// tb_blob_frame_streamer: directed sequence with randomized pixel data and
// gaps, checked against a frame-level reference model (mask bits computed
// from gray/threshold and raster position, queued in capture order).
module tb_blob_frame_streamer;

  localparam int COL  = 16;
  localparam int ROW  = 8;
  localparam int NPIX = COL * ROW;
  localparam int AW   = 7;

  logic       i_clk, i_rst_n, i_sof, i_pix_valid, i_blob_done;
  logic [7:0] i_gray, i_threshold;
  logic       o_valid, o_seq, o_busy;
  logic [7:0] o_drop_cnt;
  logic [2:0] o_state;

  logic [0:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         drop_model = 0;
  int         stream_ones = 0;

  blob_frame_streamer #(.IMG_COL(COL), .IMG_ROW(ROW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sof(i_sof), .i_pix_valid(i_pix_valid),
    .i_gray(i_gray), .i_threshold(i_threshold), .i_blob_done(i_blob_done),
    .o_valid(o_valid), .o_seq(o_seq), .o_busy(o_busy),
    .o_drop_cnt(o_drop_cnt), .o_state(o_state)
  );

  // Clock and watchdog.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference mask bit for pixel idx of a frame.
  function automatic logic model_bit(input int idx, input logic [7:0] g, input logic [7:0] t);
    int   r;
    int   c;
    logic b;
    r = idx / COL;
    c = idx % COL;
    b = (g >= t);
`ifdef BLOB_BORDER_CLEAR_EN
    if (r == 0 || r == ROW - 1 || c == 0 || c == COL - 1) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [7:0] gray_for(input int mode, input int idx);
    case (mode)
      0:       return 8'd200;
      1:       return (((idx / COL) + (idx % COL)) % 2 == 1) ? 8'd255 : 8'd0;
      2:       return 8'($urandom_range(0, 255));
      default: return 8'd255;
    endcase
  endfunction

  function automatic void count_drop();
    if (drop_model < 255) drop_model++;
  endfunction

  // Driver: one frame of pixels. abort_at >= 0 restarts the frame with an
  // i_sof coinciding with that pixel. now=1 raises i_sof in the current cycle.
  task automatic send_frame(input int mode, input int gap_max, input int abort_at, input bit now);
    int         idx;
    bit         aborted;
    logic [7:0] g;
    logic [7:0] t;
    idx = 0;
    aborted = 1'b0;
    if (!now) @(negedge i_clk);
    i_sof = 1'b1;
    i_pix_valid = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    i_sof = 1'b0;
    chk("busy_after_sof", o_busy, 1);
    while (idx < NPIX) begin
      g = gray_for(mode, idx);
      t = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'd128;
      i_pix_valid = 1'b1;
      i_blob_done = 1'b0;
      i_gray = g;
      i_threshold = t;
      if (!aborted && abort_at >= 0 && idx == abort_at) begin
        i_sof = 1'b1;
        aborted = 1'b1;
        exp_q.delete();
        idx = 0;
      end else begin
        exp_q.push_back(model_bit(idx, g, t));
        idx++;
      end
      @(negedge i_clk);
      i_sof = 1'b0;
      i_pix_valid = 1'b0;
      if (idx < NPIX) begin
        chk("no_early_valid", o_valid, 0);
        repeat ($urandom_range(0, gap_max)) begin
          i_gray = 8'($urandom);
          i_blob_done = ($urandom_range(0, 7) == 0);
          @(negedge i_clk);
        end
        i_blob_done = 1'b0;
      end
    end
  endtask

  // Stream checker. drop_at* inject i_sof before those bit cycles;
  // rst_at >= 0 pulses reset at that bit and abandons the frame.
  task automatic check_stream(input int d0, input int d1, input int d2, input int rst_at);
    int         waited;
    logic [0:0] e;
    waited = 0;
    stream_ones = 0;
    while (o_valid !== 1'b1 && waited < 8) begin
      @(negedge i_clk);
      waited++;
    end
    chk("start_latency", waited, 0);
    if (o_valid !== 1'b1) begin
      chk("start_seen", o_valid, 1);
      exp_q.delete();
      return;
    end
    chk("start_seq_zero", o_seq, 0);
    for (int k = 0; k < NPIX; k++) begin
      i_sof = (k == d0 || k == d1 || k == d2);
      if (i_sof) count_drop();
      @(negedge i_clk);
      i_sof = 1'b0;
      if (k == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_seq", o_seq, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop_cnt, 0);
        drop_model = 0;
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        return;
      end
      e = exp_q.pop_front();
      if (o_seq === 1'b1) stream_ones++;
      chk($sformatf("stream_bit%0d", k), o_seq, e);
      chk("stream_valid_low", o_valid, 0);
    end
    @(negedge i_clk);
    chk("trail_seq", o_seq, 0);
    chk("trail_busy", o_busy, 1);
    chk("drop_cnt", o_drop_cnt, drop_model);
  endtask

  // Wait state: optional i_sof storm, then i_blob_done (with i_sof if asked).
  task automatic finish_frame(input bit with_sof, input int wait_sofs);
    repeat (wait_sofs) begin
      i_sof = 1'b1;
      count_drop();
      @(negedge i_clk);
    end
    i_sof = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      @(negedge i_clk);
      chk("wait_busy", o_busy, 1);
      chk("wait_seq", o_seq, 0);
    end
    chk("wait_drop", o_drop_cnt, drop_model);
    i_blob_done = 1'b1;
    i_sof = with_sof;
    if (with_sof) count_drop();
    @(negedge i_clk);
    i_blob_done = 1'b0;
    i_sof = 1'b0;
    chk("idle_after_done", o_busy, 0);
    chk("idle_state", o_state, 0);
    chk("drop_after_done", o_drop_cnt, drop_model);
  endtask

  // Directed sequence.
  initial begin
    i_rst_n = 1'b0;
    i_sof = 1'b0;
    i_pix_valid = 1'b0;
    i_gray = 8'd0;
    i_threshold = 8'd0;
    i_blob_done = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset_valid", o_valid, 0);
    chk("reset_seq", o_seq, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_drop", o_drop_cnt, 0);
    chk("reset_state", o_state, 0);
    i_rst_n = 1'b1;

    // Pixels and i_blob_done without i_sof are ignored in idle.
    repeat (5) begin
      @(negedge i_clk);
      i_pix_valid = 1'b1;
      i_blob_done = 1'b1;
      i_gray = 8'($urandom);
      @(negedge i_clk);
      i_pix_valid = 1'b0;
      i_blob_done = 1'b0;
      chk("idle_ignore_busy", o_busy, 0);
    end

    // Uniform frame above threshold: all ones.
    send_frame(0, 0, -1, 1'b0);
    check_stream(-1, -1, -1, -1);
    chk("uniform_ones", stream_ones, NPIX);
    finish_frame(1'b0, 0);

    // Checkerboard with gaps; done coincides with a dropped i_sof, and the
    // next frame starts on the very next cycle.
    send_frame(1, 3, -1, 1'b0);
    check_stream(-1, -1, -1, -1);
    finish_frame(1'b1, 0);
    chk("drop_simul", o_drop_cnt, 1);

    send_frame(2, 3, -1, 1'b1);
    check_stream(0, 40, NPIX - 1, -1);
    chk("drop_three_more", o_drop_cnt, 4);
    finish_frame(1'b0, 300);
    chk("drop_saturate", o_drop_cnt, 255);

    // Restart mid-capture: only the second frame is streamed.
    send_frame(2, 2, 50, 1'b0);
    check_stream(-1, -1, -1, -1);
    finish_frame(1'b0, 0);

    // Reset in the middle of a stream, then a clean all-255 frame.
    send_frame(2, 1, -1, 1'b0);
    check_stream(-1, -1, -1, 50);
    chk("post_reset_state", o_state, 0);
    send_frame(3, 1, -1, 1'b0);
    check_stream(-1, -1, -1, -1);
`ifdef BLOB_BORDER_CLEAR_EN
    chk("border_ones", stream_ones, (COL - 2) * (ROW - 2));
`else
    chk("all255_ones", stream_ones, NPIX);
`endif
    finish_frame(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
